// File: rtl/wb_dual_master_arbiter.sv
// Two-master Wishbone arbiter: instruction fetch (m0) and data (m1) share one slave port.
// Optional watchdog termination is built when ARB_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no owner; slave port quiet, pending requests arbitrated at the next edge
// BUSY_M0 | m0 owns the slave port until ack, abort or watchdog expiry
// BUSY_M1 | m1 owns the slave port until ack, abort or watchdog expiry
module wb_dual_master_arbiter #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           PRIORITY_MODE  = 0,
  parameter int unsigned           TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  output logic                    m0_ack,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  output logic                    m1_ack,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_ack,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_M0 = 2'd1;
  localparam logic [1:0] BUSY_M1 = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       m0_req, m1_req;
  logic       busy_m0, busy_m1;
  logic       owner_cyc;
  logic       timeout_hit;

  assign m0_req    = m0_cyc & m0_stb;
  assign m1_req    = m1_cyc & m1_stb;
  assign busy_m0   = (state_q == BUSY_M0);
  assign busy_m1   = (state_q == BUSY_M1);
  assign owner_cyc = (busy_m0 & m0_cyc) | (busy_m1 & m1_cyc);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned       WDOG_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

  logic [WDOG_W-1:0] wdog_q, wdog_d;

  assign timeout_hit = (busy_m0 | busy_m1) & (wdog_q == WDOG_LIMIT);

  // Counts only while the owner keeps its cycle open; every return to IDLE clears it.
  always_comb begin
    wdog_d = '0;
    if ((busy_m0 | busy_m1) && !timeout_hit && !s_ack && owner_cyc) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  // No watchdog: BUSY waits for the slave indefinitely.
  localparam bit WDOG_BUILT = (TIMEOUT_CYCLES == 0) && 1'b0;
  assign timeout_hit = WDOG_BUILT;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          // Round-robin hands the port to whoever did not win last time.
          if ((PRIORITY_MODE != 0) || !last_grant_q) begin
            state_d      = BUSY_M1;
            last_grant_d = 1'b1;
          end else begin
            state_d      = BUSY_M0;
            last_grant_d = 1'b0;
          end
        end else if (m0_req) begin
          state_d      = BUSY_M0;
          last_grant_d = 1'b0;
        end else if (m1_req) begin
          state_d      = BUSY_M1;
          last_grant_d = 1'b1;
        end
      end
      BUSY_M0: begin
        if (timeout_hit || s_ack || !m0_cyc) begin
          state_d = IDLE;
        end
      end
      BUSY_M1: begin
        if (timeout_hit || s_ack || !m1_cyc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_sel     = '0;
    s_addr    = '0;
    s_data_o  = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_data_o = s_data_i;
    m1_data_o = s_data_i;
    grant_o   = 2'b00;
    timeout_o = timeout_hit;
    case (state_q)
      BUSY_M0: begin
        s_cyc    = m0_cyc & ~timeout_hit;
        s_stb    = m0_stb & ~timeout_hit;
        s_we     = m0_we;
        s_sel    = m0_sel;
        s_addr   = m0_addr;
        s_data_o = m0_data_i;
        m0_ack   = s_ack | timeout_hit;
        grant_o  = 2'b01;
        if (timeout_hit) begin
          m0_data_o = TIMEOUT_DATA;
        end
      end
      BUSY_M1: begin
        s_cyc    = m1_cyc & ~timeout_hit;
        s_stb    = m1_stb & ~timeout_hit;
        s_we     = m1_we;
        s_sel    = m1_sel;
        s_addr   = m1_addr;
        s_data_o = m1_data_i;
        m1_ack   = s_ack | timeout_hit;
        grant_o  = 2'b10;
        if (timeout_hit) begin
          m1_data_o = TIMEOUT_DATA;
        end
      end
      default: begin
        grant_o = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Bench for wb_dual_master_arbiter: directed scenarios plus randomized traffic against a cycle model.
// The watchdog scenario and model term are active only when ARB_TIMEOUT_EN is defined.
module tb_wb_dual_master_arbiter;
  localparam int          TO      = 8;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic        clk_core = 1'b0;
  logic        rst_core = 1'b0;

  logic        m0_cyc, m0_stb, m0_we, m0_ack;
  logic [3:0]  m0_sel;
  logic [31:0] m0_addr, m0_data_i, m0_data_o;
  logic        m1_cyc, m1_stb, m1_we, m1_ack;
  logic [3:0]  m1_sel;
  logic [31:0] m1_addr, m1_data_i, m1_data_o;
  logic        s_cyc, s_stb, s_we, s_ack, timeout_o;
  logic [3:0]  s_sel;
  logic [31:0] s_addr, s_data_o, s_data_i;
  logic [1:0]  grant_o;

  logic        p_m0_cyc, p_m0_stb, p_m0_we, p_m0_ack;
  logic [3:0]  p_m0_sel;
  logic [31:0] p_m0_addr, p_m0_data_i, p_m0_data_o;
  logic        p_m1_cyc, p_m1_stb, p_m1_we, p_m1_ack;
  logic [3:0]  p_m1_sel;
  logic [31:0] p_m1_addr, p_m1_data_i, p_m1_data_o;
  logic        p_s_cyc, p_s_stb, p_s_we, p_s_ack, p_timeout_o;
  logic [3:0]  p_s_sel;
  logic [31:0] p_s_addr, p_s_data_o, p_s_data_i;
  logic [1:0]  p_grant_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_core = ~clk_core;

  wb_dual_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0),
                           .TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TO_DATA)) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_addr(s_addr),
    .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack(s_ack),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  wb_dual_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(1),
                           .TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TO_DATA)) dut_p (
    .clk_core(clk_core), .rst_core(rst_core),
    .m0_cyc(p_m0_cyc), .m0_stb(p_m0_stb), .m0_we(p_m0_we), .m0_sel(p_m0_sel), .m0_addr(p_m0_addr),
    .m0_data_i(p_m0_data_i), .m0_data_o(p_m0_data_o), .m0_ack(p_m0_ack),
    .m1_cyc(p_m1_cyc), .m1_stb(p_m1_stb), .m1_we(p_m1_we), .m1_sel(p_m1_sel), .m1_addr(p_m1_addr),
    .m1_data_i(p_m1_data_i), .m1_data_o(p_m1_data_o), .m1_ack(p_m1_ack),
    .s_cyc(p_s_cyc), .s_stb(p_s_stb), .s_we(p_s_we), .s_sel(p_s_sel), .s_addr(p_s_addr),
    .s_data_o(p_s_data_o), .s_data_i(p_s_data_i), .s_ack(p_s_ack),
    .grant_o(p_grant_o), .timeout_o(p_timeout_o)
  );

  function automatic logic [75:0] ctl_bus();
    return {s_cyc, s_stb, s_we, s_sel, s_addr, s_data_o, m0_ack, m1_ack, grant_o, timeout_o};
  endfunction

  function automatic logic [75:0] p_ctl_bus();
    return {p_s_cyc, p_s_stb, p_s_we, p_s_sel, p_s_addr, p_s_data_o, p_m0_ack, p_m1_ack,
            p_grant_o, p_timeout_o};
  endfunction

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic idle_inputs();
    {m0_cyc, m0_stb, m0_we, m0_sel, m0_addr, m0_data_i} = '0;
    {m1_cyc, m1_stb, m1_we, m1_sel, m1_addr, m1_data_i} = '0;
    {s_ack, s_data_i} = '0;
    {p_m0_cyc, p_m0_stb, p_m0_we, p_m0_sel, p_m0_addr, p_m0_data_i} = '0;
    {p_m1_cyc, p_m1_stb, p_m1_we, p_m1_sel, p_m1_addr, p_m1_data_i} = '0;
    {p_s_ack, p_s_data_i} = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_core = 1'b1;
    tick();
    rst_core = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_core = 1'b1;
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_addr = 32'h1234; m0_data_i = 32'h55;
    p_m1_cyc = 1; p_m1_stb = 1; p_m1_addr = 32'h88;
    s_ack = 1; s_data_i = 32'h99; p_s_ack = 1;
    tick();
    tick();
    checks++;
    if (ctl_bus() !== 76'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", ctl_bus());
    end
    checks++;
    if (p_ctl_bus() !== 76'd0) begin
      errors++; $display("FAIL reset_outputs_prio: got %h expected 0", p_ctl_bus());
    end
    idle_inputs();
    rst_core = 1'b0;
    tick();
  endtask

  task automatic test_m0_read();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_addr = 32'h100;
    tick();
    checks++;
    if ({grant_o, s_stb, s_addr, m0_ack, m1_ack} !== {2'b01, 1'b1, 32'h100, 1'b0, 1'b0}) begin
      errors++; $display("FAIL m0_read_grant: got grant=%b stb=%b addr=%h ack0=%b ack1=%b expected 01 1 00000100 0 0",
                         grant_o, s_stb, s_addr, m0_ack, m1_ack);
    end
    tick();
    checks++;
    if ({grant_o, m0_ack} !== {2'b01, 1'b0}) begin
      errors++; $display("FAIL m0_read_wait: got grant=%b ack0=%b expected 01 0", grant_o, m0_ack);
    end
    tick();
    s_ack = 1; s_data_i = 32'h0000_0013;
    #1;
    checks++;
    if ({m0_ack, m1_ack, m0_data_o, grant_o} !== {1'b1, 1'b0, 32'h13, 2'b01}) begin
      errors++; $display("FAIL m0_read_ack: got ack0=%b ack1=%b data=%h grant=%b expected 1 0 00000013 01",
                         m0_ack, m1_ack, m0_data_o, grant_o);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({grant_o, m0_ack} !== {2'b00, 1'b0}) begin
      errors++; $display("FAIL m0_read_done: got grant=%b ack0=%b expected 00 0", grant_o, m0_ack);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'hA0;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'hB0;
    s_ack = 1; s_data_i = 32'h3C;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 1) exp_g = 2'b00;
      else exp_g = ((i / 2) % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (exp_g == 2'b01) ? 32'hA0 : ((exp_g == 2'b10) ? 32'hB0 : 32'h0);
      checks++;
      if ({grant_o, m0_ack, m1_ack, s_addr} !== {exp_g, exp_g[0], exp_g[1], exp_a}) begin
        errors++; $display("FAIL round_robin[%0d]: got grant=%b ack=%b%b addr=%h expected grant=%b addr=%h",
                           i, grant_o, m1_ack, m0_ack, s_addr, exp_g, exp_a);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_fixed_priority();
    logic [1:0] exp_g;
    idle_inputs();
    p_m0_cyc = 1; p_m0_stb = 1; p_m0_addr = 32'hA4;
    p_m1_cyc = 1; p_m1_stb = 1; p_m1_addr = 32'hB4;
    p_s_ack = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b00;
      checks++;
      if ({p_grant_o, p_m0_ack, p_m1_ack} !== {exp_g, 1'b0, exp_g[1]}) begin
        errors++; $display("FAIL fixed_priority[%0d]: got grant=%b ack0=%b ack1=%b expected grant=%b ack0=0",
                           i, p_grant_o, p_m0_ack, p_m1_ack, exp_g);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_m1_write();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'b0011;
    m1_addr = 32'h2000; m1_data_i = 32'hCAFE_BABE;
    tick();
    checks++;
    if ({s_we, s_sel, s_data_o, s_addr, grant_o, m1_ack} !==
        {1'b1, 4'b0011, 32'hCAFE_BABE, 32'h2000, 2'b10, 1'b0}) begin
      errors++; $display("FAIL m1_write_bus: got we=%b sel=%b data=%h addr=%h grant=%b ack1=%b",
                         s_we, s_sel, s_data_o, s_addr, grant_o, m1_ack);
    end
    s_ack = 1;
    #1;
    checks++;
    if ({m1_ack, m0_ack} !== 2'b10) begin
      errors++; $display("FAIL m1_write_ack: got ack1=%b ack0=%b expected 1 0", m1_ack, m0_ack);
    end
    tick();
    checks++;
    if ({grant_o, m1_ack} !== {2'b00, 1'b0}) begin
      errors++; $display("FAIL m1_write_idle_ack: got grant=%b ack1=%b expected 00 0", grant_o, m1_ack);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_abort();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h300;
    tick();
    checks++;
    if (grant_o !== 2'b01) begin
      errors++; $display("FAIL abort_grant: got %b expected 01", grant_o);
    end
    m0_cyc = 0;
    #1;
    checks++;
    if ({s_cyc, m0_ack} !== 2'b00) begin
      errors++; $display("FAIL abort_cyc: got s_cyc=%b ack0=%b expected 0 0", s_cyc, m0_ack);
    end
    tick();
    checks++;
    if (grant_o !== 2'b00) begin
      errors++; $display("FAIL abort_idle: got %b expected 00", grant_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_ack_abort();
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h400;
    tick();
    m1_cyc = 0; s_ack = 1; s_data_i = 32'h5A5A_1234;
    #1;
    checks++;
    if ({m1_ack, m1_data_o} !== {1'b1, 32'h5A5A_1234}) begin
      errors++; $display("FAIL ack_abort: got ack1=%b data=%h expected 1 5a5a1234", m1_ack, m1_data_o);
    end
    tick();
    checks++;
    if ({grant_o, m1_ack} !== {2'b00, 1'b0}) begin
      errors++; $display("FAIL ack_abort_idle: got grant=%b ack1=%b expected 00 0", grant_o, m1_ack);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF; m1_addr = 32'h44; m1_data_i = 32'h1;
    tick();
    checks++;
    if (grant_o !== 2'b10) begin
      errors++; $display("FAIL reset_mid_grant: got %b expected 10", grant_o);
    end
    rst_core = 1;
    tick();
    s_ack = 1; s_data_i = 32'h77;
    #1;
    checks++;
    if (ctl_bus() !== 76'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h expected 0", ctl_bus());
    end
    rst_core = 0; s_ack = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h80;
    tick();
    checks++;
    if ({grant_o, s_addr} !== {2'b01, 32'h80}) begin
      errors++; $display("FAIL reset_mid_first_grant: got grant=%b addr=%h expected 01 00000080", grant_o, s_addr);
    end
    s_ack = 1;
    tick();
    idle_inputs();
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h500; s_data_i = 32'h1234_5678;
    tick();
    for (int k = 0; k < TO; k++) begin
      checks++;
      if ({timeout_o, m0_ack, grant_o} !== 4'b0001) begin
        errors++; $display("FAIL timeout_early[%0d]: got to=%b ack0=%b grant=%b expected 0 0 01",
                           k, timeout_o, m0_ack, grant_o);
      end
      tick();
    end
    checks++;
    if ({timeout_o, m0_ack, s_cyc, s_stb, m0_data_o, m1_data_o} !==
        {1'b1, 1'b1, 1'b0, 1'b0, TO_DATA, 32'h1234_5678}) begin
      errors++; $display("FAIL timeout_fire: got to=%b ack0=%b cyc=%b stb=%b d0=%h d1=%h",
                         timeout_o, m0_ack, s_cyc, s_stb, m0_data_o, m1_data_o);
    end
    m0_cyc = 0; m0_stb = 0;
    tick();
    checks++;
    if ({grant_o, timeout_o} !== 3'b000) begin
      errors++; $display("FAIL timeout_idle: got grant=%b to=%b expected 00 0", grant_o, timeout_o);
    end
    s_ack = 1;
    #1;
    checks++;
    if (m0_ack !== 1'b0) begin
      errors++; $display("FAIL timeout_late_ack: got ack0=%b expected 0", m0_ack);
    end
    idle_inputs();
    tick();
  endtask
`endif

  task automatic test_random();
    int          owner, last, cnt, pick;
    bit          tmo, xc, xs, xw, r0, r1;
    logic [3:0]  xsel;
    logic [31:0] xa, xd;
    logic [139:0] exp_v, obs_v;
    do_reset();
    owner = -1; last = 1; cnt = 0;
    for (int i = 0; i < 600; i++) begin
      rst_core  = ($urandom_range(0, 79) == 0);
      m0_cyc    = ($urandom_range(0, 3) != 0);
      m0_stb    = ($urandom_range(0, 4) != 0);
      m0_we     = 1'($urandom_range(0, 1));
      m0_sel    = 4'($urandom_range(0, 15));
      m0_addr   = $urandom;
      m0_data_i = $urandom;
      m1_cyc    = ($urandom_range(0, 3) != 0);
      m1_stb    = ($urandom_range(0, 4) != 0);
      m1_we     = 1'($urandom_range(0, 1));
      m1_sel    = 4'($urandom_range(0, 15));
      m1_addr   = $urandom;
      m1_data_i = $urandom;
      s_ack     = ($urandom_range(0, 2) == 0);
      s_data_i  = $urandom;
      #1;
      tmo = 0;
`ifdef ARB_TIMEOUT_EN
      if (owner >= 0 && cnt == TO) tmo = 1;
`endif
      if (owner < 0) begin
        exp_v = {76'd0, s_data_i, s_data_i};
      end else begin
        xc   = (owner == 0) ? m0_cyc : m1_cyc;
        xs   = (owner == 0) ? m0_stb : m1_stb;
        xw   = (owner == 0) ? m0_we : m1_we;
        xsel = (owner == 0) ? m0_sel : m1_sel;
        xa   = (owner == 0) ? m0_addr : m1_addr;
        xd   = (owner == 0) ? m0_data_i : m1_data_i;
        exp_v = {xc & ~tmo, xs & ~tmo, xw, xsel, xa, xd,
                 (owner == 0) & (s_ack | tmo), (owner == 1) & (s_ack | tmo),
                 (owner == 0) ? 2'b01 : 2'b10, tmo,
                 ((owner == 0) && tmo) ? TO_DATA : s_data_i,
                 ((owner == 1) && tmo) ? TO_DATA : s_data_i};
      end
      obs_v = {ctl_bus(), m0_data_o, m1_data_o};
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL random[%0d]: got %h expected %h", i, obs_v, exp_v);
      end
      @(posedge clk_core);
      if (rst_core) begin
        owner = -1; last = 1; cnt = 0;
      end else if (owner < 0) begin
        r0 = m0_cyc && m0_stb;
        r1 = m1_cyc && m1_stb;
        pick = -1;
        if (r0 && r1) pick = (last == 0) ? 1 : 0;
        else if (r0) pick = 0;
        else if (r1) pick = 1;
        if (pick >= 0) begin
          owner = pick; last = pick; cnt = 0;
        end
      end else begin
        xc = (owner == 0) ? m0_cyc : m1_cyc;
        if (tmo || s_ack || !xc) begin
          owner = -1; cnt = 0;
        end else begin
          cnt++;
        end
      end
      #1;
    end
    rst_core = 0;
    idle_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish expected finish before 200000");
    $fatal(1, "time limit");
  end

  initial begin
    idle_inputs();
    tick();
    test_reset();
    test_m0_read();
    test_round_robin();
    test_fixed_priority();
    test_m1_write();
    test_abort();
    test_ack_abort();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
